// File: rtl/layer_tdm_sched.sv
// Time-multiplexed LogicNets layer scheduler: one neuron per clock through a shared connectivity ROM and neuron LUT.
// Optional selection-range error flag: define LAYER_TDM_RANGE_CHK_EN.
module layer_tdm_sched #(
  parameter int IN_CH   = 16,
  parameter int IN_BW   = 2,
  parameter int FANIN   = 3,
  parameter int OUT_BW  = 2,
  parameter int NEURONS = 64,
  parameter int IDX_W   = 4,
  parameter int NID_W   = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_CH*IN_BW-1:0]        in_data,
  output logic                          conn_rd_en,
  output logic [NID_W-1:0]              conn_addr,
  input  logic [FANIN*IDX_W-1:0]        conn_data,
  output logic                          lut_rd_en,
  output logic [NID_W+FANIN*IN_BW-1:0]  lut_addr,
  input  logic [OUT_BW-1:0]             lut_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NEURONS*OUT_BW-1:0]     out_data,
  output logic                          err,
  output logic [1:0]                    state_dbg
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high. in_ready depends on state and out_ready only, never on in_valid;
  // out_valid stays high with stable out_data until it is accepted.

  localparam int M0_W = FANIN*IN_BW;
  localparam logic [NID_W-1:0] LAST_NID = NID_W'(NEURONS-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [NID_W-1:0]         cnt, cnt_nxt;
  logic                     drain_cnt, drain_nxt;
  logic                     load;
  logic [IN_CH*IN_BW-1:0]   in_reg;
  logic                     s2_valid;
  logic [NID_W-1:0]         s2_nid;
  logic                     s3_valid;
  logic [NID_W-1:0]         s3_nid;
  logic [M0_W-1:0]          m0;
  logic [IDX_W-1:0]         sel;
  logic [IN_BW-1:0]         chv;

  assign state_dbg = state;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    drain_nxt  = drain_cnt;
    load       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    conn_rd_en = 1'b0;
    conn_addr  = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        conn_rd_en = 1'b1;
        conn_addr  = cnt;
        cnt_nxt    = cnt + 1'b1;
        if (cnt == LAST_NID) begin
          drain_nxt = 1'b0;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Two cycles let the last neuron pass the LUT read and the capture stage.
        drain_nxt = 1'b1;
        if (drain_cnt) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Channel gather; a selection matching no channel leaves the field at zero.
  always_comb begin
    m0  = '0;
    sel = '0;
    chv = '0;
    for (int k = 0; k < FANIN; k++) begin
      sel = conn_data[k*IDX_W +: IDX_W];
      chv = '0;
      for (int c = 0; c < IN_CH; c++) begin
        if (sel == IDX_W'(c)) chv = in_reg[c*IN_BW +: IN_BW];
      end
      m0[k*IN_BW +: IN_BW] = chv;
    end
  end

  assign lut_rd_en = s2_valid;
  assign lut_addr  = s2_valid ? {s2_nid, m0} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      drain_cnt <= 1'b0;
      in_reg    <= '0;
      s2_valid  <= 1'b0;
      s2_nid    <= '0;
      s3_valid  <= 1'b0;
      s3_nid    <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      drain_cnt <= drain_nxt;
      if (load) in_reg <= in_data;
      s2_valid  <= conn_rd_en;
      s2_nid    <= conn_addr;
      s3_valid  <= s2_valid;
      s3_nid    <= s2_nid;
      for (int n = 0; n < NEURONS; n++) begin
        if (s3_valid && (s3_nid == NID_W'(n))) out_data[n*OUT_BW +: OUT_BW] <= lut_data;
      end
    end
  end

`ifdef LAYER_TDM_RANGE_CHK_EN
  logic oor;
  logic err_r;

  always_comb begin
    oor = 1'b0;
    for (int k = 0; k < FANIN; k++) begin
      if ({1'b0, conn_data[k*IDX_W +: IDX_W]} >= (IDX_W+1)'(IN_CH)) oor = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_r <= 1'b0;
    else if (s2_valid && oor) err_r <= 1'b1;
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule
